// File: rtl/serial_link_bringup_ctrl.sv
// Serial link bring-up sequencer.
// Walks the link through reset/clock programming, optional channel-allocator
// setup, a settle wait and AXI de-isolation, then polls ISOLATED until the
// link reports ready. Poll timeouts restart the whole sequence a bounded
// number of times; bus errors abort immediately.

package serial_link_bringup_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } cfg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } cfg_rsp_t;

    localparam int unsigned NumChannels = 4;

    localparam logic [31:0] SERIAL_LINK_CTRL_OFFSET      = 32'h0000_0000;
    localparam logic [31:0] SERIAL_LINK_ISOLATED_OFFSET  = 32'h0000_0004;
    localparam logic [31:0] SERIAL_LINK_ALLOC_TX_OFFSET  = 32'h0000_0010;
    localparam logic [31:0] SERIAL_LINK_ALLOC_RX_OFFSET  = 32'h0000_0014;

endpackage

module serial_link_bringup_ctrl #(
    parameter type         cfg_req_t     = serial_link_bringup_pkg::cfg_req_t,
    parameter type         cfg_rsp_t     = serial_link_bringup_pkg::cfg_rsp_t,
    parameter int unsigned NumChannels   = serial_link_bringup_pkg::NumChannels,
    parameter logic [31:0] CtrlOffset    = serial_link_bringup_pkg::SERIAL_LINK_CTRL_OFFSET,
    parameter logic [31:0] IsoOffset     = serial_link_bringup_pkg::SERIAL_LINK_ISOLATED_OFFSET,
    parameter logic [31:0] AllocTxOffset = serial_link_bringup_pkg::SERIAL_LINK_ALLOC_TX_OFFSET,
    parameter logic [31:0] AllocRxOffset = serial_link_bringup_pkg::SERIAL_LINK_ALLOC_RX_OFFSET,
    parameter logic [31:0] AllocCfg      = 32'h3,
    parameter int unsigned SettleCycles  = 50,
    parameter int unsigned PollGap       = 4,
    parameter int unsigned MaxPolls      = 64,
    parameter int unsigned MaxRetries    = 3
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              start_i,
    output cfg_req_t                          cfg_req_o,
    input  cfg_rsp_t                          cfg_rsp_i,
    output logic                              busy_o,
    output logic                              ready_o,
    output logic                              fail_o,
    output logic [1:0]                        fail_cause_o,
    output logic [$clog2(MaxRetries+2)-1:0]   attempt_o
);

    localparam int unsigned AttemptW = $clog2(MaxRetries + 2);
    localparam int unsigned SettleW  = $clog2(SettleCycles + 1);
    localparam int unsigned PollW    = $clog2(MaxPolls + 1);
    localparam int unsigned GapW     = (PollGap > 0) ? $clog2(PollGap + 1) : 1;
    localparam int unsigned GapLastI = (PollGap > 0) ? PollGap - 1 : 0;

    localparam logic [SettleW-1:0]  SettleLast = SettleW'(SettleCycles - 1);
    localparam logic [PollW-1:0]    PollMax    = PollW'(MaxPolls);
    localparam logic [GapW-1:0]     GapLast    = GapW'(GapLastI);
    localparam logic [AttemptW-1:0] RetryMax   = AttemptW'(MaxRetries);

    localparam logic [1:0] CauseNone    = 2'd0;
    localparam logic [1:0] CauseBusErr  = 2'd1;
    localparam logic [1:0] CauseTimeout = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_W_RST_LO,
        ST_W_RST_HI,
        ST_W_CLK,
        ST_W_ALLOC_TX,
        ST_W_ALLOC_RX,
        ST_SETTLE,
        ST_W_DEISO,
        ST_R_ISO,
        ST_POLL_GAP,
        ST_DONE,
        ST_FAIL
    } state_e;

    state_e                state_q, state_d;
    logic [SettleW-1:0]    settle_cnt_q, settle_cnt_d;
    logic [PollW-1:0]      poll_cnt_q, poll_cnt_d;
    logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;
    logic [AttemptW-1:0]   attempt_q, attempt_d;
    logic                  busy_q, busy_d;
    logic                  ready_q, ready_d;
    logic                  fail_q, fail_d;
    logic [1:0]            cause_q, cause_d;
    logic [PollW-1:0]      poll_inc;
    logic                  xfer_done;

    // Bus request decoded from the current state so reset drops valid at once
    always_comb begin
        cfg_req_o = '0;
        unique case (state_q)
            ST_W_RST_LO: begin
                cfg_req_o.valid = 1'b1;
                cfg_req_o.write = 1'b1;
                cfg_req_o.addr  = CtrlOffset;
                cfg_req_o.wdata = 32'h0000_0300;
                cfg_req_o.wstrb = '1;
            end
            ST_W_RST_HI: begin
                cfg_req_o.valid = 1'b1;
                cfg_req_o.write = 1'b1;
                cfg_req_o.addr  = CtrlOffset;
                cfg_req_o.wdata = 32'h0000_0302;
                cfg_req_o.wstrb = '1;
            end
            ST_W_CLK: begin
                cfg_req_o.valid = 1'b1;
                cfg_req_o.write = 1'b1;
                cfg_req_o.addr  = CtrlOffset;
                cfg_req_o.wdata = 32'h0000_0303;
                cfg_req_o.wstrb = '1;
            end
            ST_W_ALLOC_TX: begin
                cfg_req_o.valid = 1'b1;
                cfg_req_o.write = 1'b1;
                cfg_req_o.addr  = AllocTxOffset;
                cfg_req_o.wdata = AllocCfg;
                cfg_req_o.wstrb = '1;
            end
            ST_W_ALLOC_RX: begin
                cfg_req_o.valid = 1'b1;
                cfg_req_o.write = 1'b1;
                cfg_req_o.addr  = AllocRxOffset;
                cfg_req_o.wdata = AllocCfg;
                cfg_req_o.wstrb = '1;
            end
            ST_W_DEISO: begin
                cfg_req_o.valid = 1'b1;
                cfg_req_o.write = 1'b1;
                cfg_req_o.addr  = CtrlOffset;
                cfg_req_o.wdata = 32'h0000_0003;
                cfg_req_o.wstrb = '1;
            end
            ST_R_ISO: begin
                cfg_req_o.valid = 1'b1;
                cfg_req_o.addr  = IsoOffset;
            end
            default: ;
        endcase
    end

    assign xfer_done = cfg_req_o.valid & cfg_rsp_i.ready;

    // Next-state, counter and status computation
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        poll_cnt_d   = poll_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        attempt_d    = attempt_q;
        ready_d      = ready_q;
        fail_d       = fail_q;
        cause_d      = cause_q;
        poll_inc     = (poll_cnt_q == PollMax) ? poll_cnt_q : poll_cnt_q + 1'b1;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start_i) begin
                    state_d      = ST_W_RST_LO;
                    ready_d      = 1'b0;
                    fail_d       = 1'b0;
                    cause_d      = CauseNone;
                    attempt_d    = '0;
                    settle_cnt_d = '0;
                    poll_cnt_d   = '0;
                    gap_cnt_d    = '0;
                end
            end
            ST_W_RST_LO:   if (xfer_done) state_d = ST_W_RST_HI;
            ST_W_RST_HI:   if (xfer_done) state_d = ST_W_CLK;
            ST_W_CLK:      if (xfer_done) state_d = (NumChannels > 1) ? ST_W_ALLOC_TX : ST_SETTLE;
            ST_W_ALLOC_TX: if (xfer_done) state_d = ST_W_ALLOC_RX;
            ST_W_ALLOC_RX: if (xfer_done) state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (settle_cnt_q >= SettleLast) begin
                    state_d      = ST_W_DEISO;
                    settle_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            ST_W_DEISO:    if (xfer_done) state_d = ST_R_ISO;
            ST_R_ISO: begin
                if (xfer_done) begin
                    if (cfg_rsp_i.rdata == '0) begin
                        state_d = ST_DONE;
                        ready_d = 1'b1;
                    end else if (poll_inc >= PollMax) begin
                        // Attempt timed out: restart from scratch or give up
                        poll_cnt_d   = '0;
                        gap_cnt_d    = '0;
                        settle_cnt_d = '0;
                        if (attempt_q < RetryMax) begin
                            attempt_d = attempt_q + 1'b1;
                            state_d   = ST_W_RST_LO;
                        end else begin
                            state_d = ST_FAIL;
                            fail_d  = 1'b1;
                            cause_d = CauseTimeout;
                        end
                    end else begin
                        poll_cnt_d = poll_inc;
                        gap_cnt_d  = '0;
                        state_d    = (PollGap == 0) ? ST_R_ISO : ST_POLL_GAP;
                    end
                end
            end
            ST_POLL_GAP: begin
                if (gap_cnt_q >= GapLast) begin
                    state_d   = ST_R_ISO;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A bus error on any completed access aborts without retry
        if (xfer_done && cfg_rsp_i.error) begin
            state_d = ST_FAIL;
            ready_d = 1'b0;
            fail_d  = 1'b1;
            cause_d = CauseBusErr;
        end

        busy_d = !(state_d inside {ST_IDLE, ST_DONE, ST_FAIL});
    end

    // State and registered status outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            poll_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            attempt_q    <= '0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
            cause_q      <= CauseNone;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            poll_cnt_q   <= poll_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            attempt_q    <= attempt_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            fail_q       <= fail_d;
            cause_q      <= cause_d;
        end
    end

    assign busy_o       = busy_q;
    assign ready_o      = ready_q;
    assign fail_o       = fail_q;
    assign fail_cause_o = cause_q;
    assign attempt_o    = attempt_q;

endmodule

// File: tb/tb_serial_link_bringup_ctrl.sv
// Testbench for serial_link_bringup_ctrl.
// dut0: four channels, 8 polls per attempt, 2 retries, scoreboarded bus slave
// with optional random stalls, scripted ISOLATED values and error injection.
// dut1: single channel, zero-wait slave, used for the latency/no-alloc case.

module tb_serial_link_bringup_ctrl;
    import serial_link_bringup_pkg::*;

    localparam logic [31:0] CTRL = SERIAL_LINK_CTRL_OFFSET;
    localparam logic [31:0] ISO  = SERIAL_LINK_ISOLATED_OFFSET;
    localparam logic [31:0] ATX  = SERIAL_LINK_ALLOC_TX_OFFSET;
    localparam logic [31:0] ARX  = SERIAL_LINK_ALLOC_RX_OFFSET;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } txn_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;

    cfg_req_t   req0, req1;
    cfg_rsp_t   rsp0 = '0;
    cfg_rsp_t   rsp1;
    logic       busy0, ready0, fail0;
    logic [1:0] cause0;
    logic [1:0] attempt0;
    logic       busy1, ready1, fail1;
    logic [1:0] cause1;
    logic [2:0] attempt1;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    txn_t exp_q[$];
    txn_t exp_e;
    bit   stall_en      = 1'b0;
    int   iso_mode      = 0;
    bit   err_arm       = 1'b0;
    int   iso_reads     = 0;
    bit   in_txn        = 1'b0;
    int   wait_cnt      = 0;
    int   last_read_cyc = -1;
    bit   check_gap     = 1'b0;
    int   n1_txn        = 0;
    int   n1_alloc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_link_bringup_ctrl #(
        .NumChannels (4),
        .SettleCycles(50),
        .PollGap     (4),
        .MaxPolls    (8),
        .MaxRetries  (2)
    ) dut0 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start0),
        .cfg_req_o   (req0),
        .cfg_rsp_i   (rsp0),
        .busy_o      (busy0),
        .ready_o     (ready0),
        .fail_o      (fail0),
        .fail_cause_o(cause0),
        .attempt_o   (attempt0)
    );

    serial_link_bringup_ctrl #(
        .NumChannels (1),
        .SettleCycles(50),
        .PollGap     (4),
        .MaxPolls    (64),
        .MaxRetries  (3)
    ) dut1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start1),
        .cfg_req_o   (req1),
        .cfg_rsp_i   (rsp1),
        .busy_o      (busy1),
        .ready_o     (ready1),
        .fail_o      (fail1),
        .fail_cause_o(cause1),
        .attempt_o   (attempt1)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Expected bus traffic of one attempt
    function automatic void push_attempt(input int nch, input int nreads);
        exp_q.push_back('{CTRL, 1'b1, 32'h300});
        exp_q.push_back('{CTRL, 1'b1, 32'h302});
        exp_q.push_back('{CTRL, 1'b1, 32'h303});
        if (nch > 1) begin
            exp_q.push_back('{ATX, 1'b1, 32'h3});
            exp_q.push_back('{ARX, 1'b1, 32'h3});
        end
        exp_q.push_back('{CTRL, 1'b1, 32'h03});
        for (int i = 0; i < nreads; i++) exp_q.push_back('{ISO, 1'b0, 32'h0});
    endfunction

    // dut0 slave: stalls, answers, and scoreboards every completed access
    always @(negedge clk) begin
        if (!rst_n) begin
            rsp0   = '0;
            in_txn = 1'b0;
        end else begin
            if (rsp0.ready) in_txn = 1'b0;
            rsp0 = '0;
            if (req0.valid) begin
                if (!in_txn) begin
                    in_txn   = 1'b1;
                    wait_cnt = stall_en ? int'($urandom_range(0, 5)) : 0;
                end
                if (wait_cnt > 0) begin
                    wait_cnt--;
                    if (exp_q.size() > 0) begin
                        check_eq("stall_addr", req0.addr, exp_q[0].addr);
                        if (exp_q[0].wr) check_eq("stall_wdata", req0.wdata, exp_q[0].data);
                    end
                end else begin
                    rsp0.ready = 1'b1;
                    if (!req0.write) begin
                        case (iso_mode)
                            0:       rsp0.rdata = 32'h0;
                            1:       rsp0.rdata = (iso_reads < 5) ? 32'h3 : 32'h0;
                            default: rsp0.rdata = 32'h1;
                        endcase
                        iso_reads++;
                    end else if (err_arm && req0.addr == CTRL && req0.wdata == 32'h303) begin
                        rsp0.error = 1'b1;
                        err_arm    = 1'b0;
                    end
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_txn", req0.addr, 32'hDEAD_BEEF);
                    end else begin
                        exp_e = exp_q.pop_front();
                        check_eq("addr", req0.addr, exp_e.addr);
                        check_eq("write", 32'(req0.write), 32'(exp_e.wr));
                        if (exp_e.wr) begin
                            check_eq("wdata", req0.wdata, exp_e.data);
                            check_eq("wstrb", 32'(req0.wstrb), 32'hF);
                        end
                    end
                    if (!req0.write) begin
                        if (check_gap && last_read_cyc >= 0)
                            check_eq("read_gap", 32'(cyc - last_read_cyc), 32'd5);
                        last_read_cyc = cyc;
                    end else begin
                        last_read_cyc = -1;
                    end
                end
            end
        end
    end

    // dut1 slave: always ready, link never isolated
    always_comb begin
        rsp1       = '0;
        rsp1.ready = req1.valid;
    end

    // dut1 access counter
    always @(negedge clk) begin
        if (req1.valid) begin
            n1_txn++;
            if (req1.addr == ATX || req1.addr == ARX) n1_alloc++;
        end
    end

    task automatic run0(input int budget, output int lat);
        int  t0;
        bit  seen;
        @(negedge clk);
        t0 = cyc;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        seen = 1'b0;
        lat  = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            if (ready0 || fail0) begin
                seen = 1'b1;
                lat  = cyc - t0;
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) check_eq("timeout_dut0", 32'd0, 32'd1);
    endtask

    task automatic run1(input int budget, output int lat);
        int  t0;
        bit  seen;
        @(negedge clk);
        t0 = cyc;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        seen = 1'b0;
        lat  = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            if (ready1 || fail1) begin
                seen = 1'b1;
                lat  = cyc - t0;
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) check_eq("timeout_dut1", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int  lat;
        bit  seen;

        // Reset values
        repeat (2) @(negedge clk);
        check_eq("rst_valid",   32'(req0.valid), 32'd0);
        check_eq("rst_busy",    32'(busy0),      32'd0);
        check_eq("rst_ready",   32'(ready0),     32'd0);
        check_eq("rst_fail",    32'(fail0),      32'd0);
        check_eq("rst_cause",   32'(cause0),     32'd0);
        check_eq("rst_attempt", 32'(attempt0),   32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full four-channel sequence, first read clean: 1+3+2+50+1+1 = 58
        push_attempt(4, 1);
        run0(300, lat);
        $display("[TB] seq4 latency=%0d ready=%0b", lat, ready0);
        check_eq("lat_nch4",   32'(lat),      32'd58);
        check_eq("t1_ready",   32'(ready0),   32'd1);
        check_eq("t1_fail",    32'(fail0),    32'd0);
        check_eq("t1_busy",    32'(busy0),    32'd0);
        check_eq("t1_attempt", 32'(attempt0), 32'd0);
        check_eq("t1_queue",   32'(exp_q.size()), 32'd0);

        // Single channel: no allocator writes, two cycles sooner
        run1(300, lat);
        $display("[TB] seq1 latency=%0d accesses=%0d alloc=%0d", lat, n1_txn, n1_alloc);
        check_eq("lat_nch1",  32'(lat),      32'd56);
        check_eq("n1_alloc",  32'(n1_alloc), 32'd0);
        check_eq("n1_txn",    32'(n1_txn),   32'd5);
        check_eq("t2_ready",  32'(ready1),   32'd1);

        // Five isolated reads then clear: six reads, 5 cycles apart
        iso_mode  = 1;
        iso_reads = 0;
        check_gap = 1'b1;
        push_attempt(4, 6);
        run0(500, lat);
        check_gap = 1'b0;
        $display("[TB] poll seq reads=%0d ready=%0b attempt=%0d", iso_reads, ready0, attempt0);
        check_eq("t3_ready",   32'(ready0),   32'd1);
        check_eq("t3_attempt", 32'(attempt0), 32'd0);
        check_eq("t3_reads",   32'(iso_reads), 32'd6);
        check_eq("t3_queue",   32'(exp_q.size()), 32'd0);

        // Stuck isolated: three attempts of eight reads, then timeout failure
        iso_mode  = 2;
        check_gap = 1'b1;
        for (int a = 0; a < 3; a++) push_attempt(4, 8);
        run0(3000, lat);
        check_gap = 1'b0;
        $display("[TB] stuck seq fail=%0b cause=%0d attempt=%0d", fail0, cause0, attempt0);
        check_eq("t4_fail",    32'(fail0),    32'd1);
        check_eq("t4_cause",   32'(cause0),   32'd2);
        check_eq("t4_attempt", 32'(attempt0), 32'd2);
        check_eq("t4_ready",   32'(ready0),   32'd0);
        check_eq("t4_queue",   32'(exp_q.size()), 32'd0);

        // Bus error on the clock-enable write
        iso_mode = 0;
        err_arm  = 1'b1;
        exp_q.push_back('{CTRL, 1'b1, 32'h300});
        exp_q.push_back('{CTRL, 1'b1, 32'h302});
        exp_q.push_back('{CTRL, 1'b1, 32'h303});
        run0(300, lat);
        $display("[TB] error seq fail=%0b cause=%0d", fail0, cause0);
        check_eq("t5_fail",    32'(fail0),    32'd1);
        check_eq("t5_cause",   32'(cause0),   32'd1);
        check_eq("t5_attempt", 32'(attempt0), 32'd0);
        repeat (10) @(negedge clk);
        check_eq("t5_idle_valid", 32'(req0.valid), 32'd0);
        check_eq("t5_idle_busy",  32'(busy0),      32'd0);
        check_eq("t5_queue",      32'(exp_q.size()), 32'd0);
        push_attempt(4, 1);
        run0(300, lat);
        $display("[TB] restart after error ready=%0b cause=%0d", ready0, cause0);
        check_eq("t5r_ready", 32'(ready0), 32'd1);
        check_eq("t5r_cause", 32'(cause0), 32'd0);
        check_eq("t5r_fail",  32'(fail0),  32'd0);

        // Random slave stalls; request stability checked by the slave model
        stall_en = 1'b1;
        push_attempt(4, 1);
        run0(3000, lat);
        stall_en = 1'b0;
        $display("[TB] stalled seq ready=%0b", ready0);
        check_eq("t6_ready", 32'(ready0), 32'd1);
        check_eq("t6_queue", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset during R_ISO of the second attempt
        iso_mode = 2;
        push_attempt(4, 8);
        push_attempt(4, 1);
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            if (attempt0 == 2'd1 && req0.valid && !req0.write) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) check_eq("timeout_riso", 32'd0, 32'd1);
        check_eq("t7_pre_busy", 32'(busy0), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("[TB] async reset in R_ISO valid=%0b busy=%0b attempt=%0d", req0.valid, busy0, attempt0);
        check_eq("t7_valid",   32'(req0.valid),  32'd0);
        check_eq("t7_addr",    req0.addr,        32'd0);
        check_eq("t7_wdata",   req0.wdata,       32'd0);
        check_eq("t7_busy",    32'(busy0),       32'd0);
        check_eq("t7_ready",   32'(ready0),      32'd0);
        check_eq("t7_fail",    32'(fail0),       32'd0);
        check_eq("t7_cause",   32'(cause0),      32'd0);
        check_eq("t7_attempt", 32'(attempt0),    32'd0);
        exp_q.delete();
        iso_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("t7_idle_valid", 32'(req0.valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
